// File: rtl/bus_mem_responder.sv
// Word-addressed memory behind a simple valid/ready bus, with programmable
// wait states, read back-pressure, abort on valid drop and range checking.
module bus_mem_responder #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DEPTH_LOG2  = 8,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  BUS_valid,
   input  logic                  BUS_mode,
   input  logic [ADDR_WIDTH-1:0] BUS_addr,
   input  logic [DATA_WIDTH-1:0] BUS_wdata,
   input  logic                  BUS_rready,
   output logic                  BUS_wready,
   output logic                  BUS_rvalid,
   output logic [DATA_WIDTH-1:0] BUS_rdata,
   output logic                  busy,
   output logic                  range_err
);

   localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned IDX_LSB = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT    = 3'd1,
      WRESP   = 3'd2,
      RRESP   = 3'd3,
      RELEASE = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    mode_q, mode_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    wready_q, wready_d;
   logic                    rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    busy_q, busy_d;
   logic                    range_err_q, range_err_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    acc_mode_c;
   logic [ADDR_WIDTH-1:0]   acc_addr_c;
   logic [DATA_WIDTH-1:0]   acc_wdata_c;
   logic [DEPTH_LOG2-1:0]   acc_idx_c;
   logic                    acc_in_range_c;
   logic                    go_resp_c;
   logic                    mem_we_c;

   // Access fields: live bus when responding straight from IDLE, latched copy otherwise
   always_comb begin
      acc_mode_c     = (state_q == IDLE) ? BUS_mode  : mode_q;
      acc_addr_c     = (state_q == IDLE) ? BUS_addr  : addr_q;
      acc_wdata_c    = (state_q == IDLE) ? BUS_wdata : wdata_q;
      acc_idx_c      = acc_addr_c[DEPTH_LOG2+IDX_LSB-1:IDX_LSB];
      acc_in_range_c = ((acc_addr_c >> (DEPTH_LOG2 + IDX_LSB)) == '0);
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wready_d    = 1'b0;
      rvalid_d    = rvalid_q;
      rdata_d     = rdata_q;
      range_err_d = 1'b0;
      go_resp_c   = 1'b0;
      mem_we_c    = 1'b0;

      case (state_q)
         IDLE: begin
            if (BUS_valid) begin
               mode_d  = BUS_mode;
               addr_d  = BUS_addr;
               wdata_d = BUS_wdata;
               if (WAIT_CYCLES == 0) begin
                  go_resp_c = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (!BUS_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               go_resp_c = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         WRESP: begin
            state_d = RELEASE;
         end
         RRESP: begin
            if (!BUS_valid || BUS_rready) begin
               state_d  = BUS_valid ? RELEASE : IDLE;
               rvalid_d = 1'b0;
               rdata_d  = '0;
            end
         end
         RELEASE: begin
            if (!BUS_valid) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Launch the response phase; the write lands on this same edge
      if (go_resp_c) begin
         range_err_d = !acc_in_range_c;
         if (acc_mode_c) begin
            state_d  = WRESP;
            wready_d = 1'b1;
            mem_we_c = acc_in_range_c;
         end else begin
            state_d  = RRESP;
            rvalid_d = 1'b1;
            rdata_d  = acc_in_range_c ? mem_q[acc_idx_c] : '0;
         end
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wready_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wready_q    <= wready_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
         range_err_q <= range_err_d;
      end
   end

   // Storage array, deliberately not reset; writes blocked while reset is held
   always_ff @(posedge clk) begin
      if (mem_we_c && rst_n) begin
         mem_q[acc_idx_c] <= acc_wdata_c;
      end
   end

   assign BUS_wready = wready_q;
   assign BUS_rvalid = rvalid_q;
   assign BUS_rdata  = rdata_q;
   assign busy       = busy_q;
   assign range_err  = range_err_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder (WAIT_CYCLES=2, DEPTH_LOG2=8).
module tb_bus_mem_responder;

   localparam int WAITS = 2;

   logic        clk;
   logic        rst_n;
   logic        BUS_valid;
   logic        BUS_mode;
   logic [31:0] BUS_addr;
   logic [31:0] BUS_wdata;
   logic        BUS_rready;
   logic        BUS_wready;
   logic        BUS_rvalid;
   logic [31:0] BUS_rdata;
   logic        busy;
   logic        range_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ref_mem   [256];
   bit          ref_known [256];

   bus_mem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .DEPTH_LOG2 (8),
      .WAIT_CYCLES(WAITS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .BUS_valid (BUS_valid),
      .BUS_mode  (BUS_mode),
      .BUS_addr  (BUS_addr),
      .BUS_wdata (BUS_wdata),
      .BUS_rready(BUS_rready),
      .BUS_wready(BUS_wready),
      .BUS_rvalid(BUS_rvalid),
      .BUS_rdata (BUS_rdata),
      .busy      (busy),
      .range_err (range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full write transaction; returns latency, range_err at response, wready one cycle later
   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic rerr, output logic wr_after);
      BUS_valid = 1'b1; BUS_mode = 1'b1; BUS_addr = a; BUS_wdata = d;
      tick();
      BUS_mode = 1'b0; BUS_addr = $urandom; BUS_wdata = $urandom;
      lat = 0;
      while (BUS_wready !== 1'b1 && lat < 20) begin tick(); lat++; end
      rerr = range_err;
      tick();
      wr_after = BUS_wready;
      BUS_valid = 1'b0;
      tick();
   endtask

   // Full read transaction with optional rready stall
   task automatic do_read(input logic [31:0] a, input int stall,
                          output int lat, output logic [31:0] rd, output logic rerr,
                          output bit stable, output logic rv_after, output logic [31:0] rd_after);
      BUS_valid = 1'b1; BUS_mode = 1'b0; BUS_addr = a; BUS_rready = 1'b0;
      tick();
      BUS_mode = 1'b1; BUS_addr = $urandom; BUS_wdata = $urandom;
      lat = 0;
      while (BUS_rvalid !== 1'b1 && lat < 20) begin tick(); lat++; end
      rd = BUS_rdata; rerr = range_err; stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
         tick();
         if (BUS_rvalid !== 1'b1 || BUS_rdata !== rd || range_err !== 1'b0) stable = 1'b0;
      end
      BUS_rready = 1'b1;
      tick();
      rv_after = BUS_rvalid; rd_after = BUS_rdata;
      BUS_rready = 1'b0; BUS_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; BUS_valid = 1'b0; BUS_mode = 1'b0; BUS_addr = '0;
      BUS_wdata = '0; BUS_rready = 1'b0;
      tick(); tick();
      n_checks++;
      if ({BUS_wready, BUS_rvalid, busy, range_err} !== 4'b0 || BUS_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got wr=%b rv=%b busy=%b rerr=%b rdata=%h, want all 0",
                  BUS_wready, BUS_rvalid, busy, range_err, BUS_rdata);
      end
      @(negedge clk); rst_n = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_write_read();
      int lat; logic rerr, wa, rva, rsv; logic [31:0] rd, rda; bit st;
      do_write(32'h10, 32'hDEADBEEF, lat, rerr, wa);
      ref_mem[4] = 32'hDEADBEEF; ref_known[4] = 1'b1;
      n_checks++;
      if (lat !== WAITS) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", lat, WAITS); end
      n_checks++;
      if (wa !== 1'b0 || rerr !== 1'b0) begin
         n_fail++; $display("FAIL wr_pulse: got wready_after=%b rerr=%b want 0 0", wa, rerr);
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle_busy: got %b want 0", busy); end
      do_read(32'h10, 0, lat, rd, rsv, st, rva, rda);
      n_checks++;
      if (lat !== WAITS) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", lat, WAITS); end
      n_checks++;
      if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd); end
      n_checks++;
      if (rva !== 1'b0 || rda !== 32'h0) begin
         n_fail++; $display("FAIL rd_release: got rvalid=%b rdata=%h want 0 0", rva, rda);
      end
   endtask

   task automatic test_rready_stall();
      int lat; logic rva, rsv; logic [31:0] rd, rda; bit st;
      do_read(32'h10, 5, lat, rd, rsv, st, rva, rda);
      n_checks++;
      if (st !== 1'b1 || rd !== ref_mem[4]) begin
         n_fail++; $display("FAIL stall_stable: got stable=%b rdata=%h want 1 %h", st, rd, ref_mem[4]);
      end
      n_checks++;
      if (rva !== 1'b0 || rda !== 32'h0) begin
         n_fail++; $display("FAIL stall_drop: got rvalid=%b rdata=%h want 0 0", rva, rda);
      end
   endtask

   task automatic test_held_valid();
      int pulses = 0; bit busy_ok = 1'b1;
      int lat; logic rva, rsv; logic [31:0] rd, rda; bit st;
      BUS_valid = 1'b1; BUS_mode = 1'b1; BUS_addr = 32'h04; BUS_wdata = 32'h0BADF00D;
      tick();
      for (int i = 0; i < 12; i++) begin
         if (BUS_wready === 1'b1) pulses++;
         if (busy !== 1'b1) busy_ok = 1'b0;
         tick();
      end
      ref_mem[1] = 32'h0BADF00D; ref_known[1] = 1'b1;
      n_checks++;
      if (pulses !== 1) begin n_fail++; $display("FAIL held_pulses: got %0d want 1", pulses); end
      n_checks++;
      if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL held_busy: got busy drop, want busy held"); end
      BUS_valid = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL held_release: got busy=%b want 0", busy); end
      do_read(32'h04, 0, lat, rd, rsv, st, rva, rda);
      n_checks++;
      if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL held_readback: got %h want 0badf00d", rd); end
   endtask

   task automatic test_range();
      int lat; logic rerr, wa, rva; logic [31:0] rd, rda; bit st;
      do_write(32'h0, 32'h55AA0001, lat, rerr, wa);
      ref_mem[0] = 32'h55AA0001; ref_known[0] = 1'b1;
      do_write(32'h400, 32'h12345678, lat, rerr, wa);
      n_checks++;
      if (lat !== WAITS || rerr !== 1'b1) begin
         n_fail++; $display("FAIL oor_write: got lat=%0d rerr=%b want %0d 1", lat, rerr, WAITS);
      end
      do_read(32'h0, 0, lat, rd, rerr, st, rva, rda);
      n_checks++;
      if (rd !== 32'h55AA0001 || rerr !== 1'b0) begin
         n_fail++; $display("FAIL oor_alias: got rdata=%h rerr=%b want 55aa0001 0", rd, rerr);
      end
      do_read(32'h400, 0, lat, rd, rerr, st, rva, rda);
      n_checks++;
      if (lat !== WAITS || rd !== 32'h0 || rerr !== 1'b1) begin
         n_fail++; $display("FAIL oor_read: got lat=%0d rdata=%h rerr=%b want %0d 0 1", lat, rd, rerr, WAITS);
      end
   endtask

   task automatic test_abort();
      int lat; int seen = 0; logic rerr, wa, rva; logic [31:0] rd, rda; bit st;
      do_write(32'h08, 32'h11112222, lat, rerr, wa);
      ref_mem[2] = 32'h11112222; ref_known[2] = 1'b1;
      BUS_valid = 1'b1; BUS_mode = 1'b1; BUS_addr = 32'h08; BUS_wdata = 32'hA5A5A5A5;
      tick();
      BUS_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (BUS_wready === 1'b1) seen++;
      end
      n_checks++;
      if (seen !== 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_write: got wready_count=%0d busy=%b want 0 0", seen, busy);
      end
      do_read(32'h08, 0, lat, rd, rerr, st, rva, rda);
      n_checks++;
      if (rd !== 32'h11112222) begin n_fail++; $display("FAIL abort_mem: got %h want 11112222", rd); end
      // read aborted while data is presented
      BUS_valid = 1'b1; BUS_mode = 1'b0; BUS_addr = 32'h08; BUS_rready = 1'b0;
      tick();
      lat = 0;
      while (BUS_rvalid !== 1'b1 && lat < 20) begin tick(); lat++; end
      BUS_valid = 1'b0;
      tick();
      n_checks++;
      if (lat !== WAITS || BUS_rvalid !== 1'b0 || BUS_rdata !== 32'h0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_read: got lat=%0d rvalid=%b rdata=%h busy=%b want %0d 0 0 0",
                  lat, BUS_rvalid, BUS_rdata, busy, WAITS);
      end
   endtask

   task automatic test_reset_in_wait();
      int lat; logic rerr, wa, rva; logic [31:0] rd, rda; bit st;
      do_write(32'h0C, 32'h33334444, lat, rerr, wa);
      ref_mem[3] = 32'h33334444; ref_known[3] = 1'b1;
      BUS_valid = 1'b1; BUS_mode = 1'b1; BUS_addr = 32'h0C; BUS_wdata = 32'hFFFF0000;
      tick();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({BUS_wready, BUS_rvalid, busy, range_err} !== 4'b0 || BUS_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_async: got wr=%b rv=%b busy=%b rerr=%b rdata=%h want all 0",
                  BUS_wready, BUS_rvalid, busy, range_err, BUS_rdata);
      end
      tick(); tick();
      BUS_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      tick();
      do_read(32'h0C, 0, lat, rd, rerr, st, rva, rda);
      n_checks++;
      if (lat !== WAITS || rd !== 32'h33334444) begin
         n_fail++; $display("FAIL rst_mem: got lat=%0d rdata=%h want %0d 33334444", lat, rd, WAITS);
      end
   endtask

   task automatic test_random_back_to_back();
      int lat; logic rerr, wa, rva; logic [31:0] rd, rda, a, d, exp_rd; bit st, oor;
      int word;
      for (int t = 0; t < 40; t++) begin
         oor  = ($urandom_range(0, 6) == 0);
         word = $urandom_range(0, 63);
         a    = (32'(word) << 2) | 32'($urandom_range(0, 3));
         if (oor) a = a | (32'h1 << $urandom_range(10, 31));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            do_write(a, d, lat, rerr, wa);
            if (!oor) begin ref_mem[word] = d; ref_known[word] = 1'b1; end
            n_checks++;
            if (lat !== WAITS || rerr !== oor || wa !== 1'b0) begin
               n_fail++;
               $display("FAIL rnd_write[%0d]: got lat=%0d rerr=%b wr_after=%b want %0d %b 0",
                        t, lat, rerr, wa, WAITS, oor);
            end
         end else begin
            do_read(a, $urandom_range(0, 3), lat, rd, rerr, st, rva, rda);
            exp_rd = oor ? 32'h0 : ref_mem[word];
            n_checks++;
            if (lat !== WAITS || rerr !== oor || st !== 1'b1) begin
               n_fail++;
               $display("FAIL rnd_read_ctl[%0d]: got lat=%0d rerr=%b stable=%b want %0d %b 1",
                        t, lat, rerr, st, WAITS, oor);
            end
            if (oor || ref_known[word]) begin
               n_checks++;
               if (rd !== exp_rd) begin
                  n_fail++; $display("FAIL rnd_read_data[%0d]: got %h want %h", t, rd, exp_rd);
               end
            end
            n_checks++;
            if (rva !== 1'b0 || rda !== 32'h0) begin
               n_fail++; $display("FAIL rnd_read_rel[%0d]: got rvalid=%b rdata=%h want 0 0", t, rva, rda);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; ref_known[i] = 1'b0; end
      test_reset();
      test_write_read();
      test_rready_stall();
      test_held_valid();
      test_range();
      test_abort();
      test_reset_in_wait();
      test_random_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, bus data width.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, bus byte-address width.
REQ-003 SHALL provide parameter DEPTH_LOG2, default 8, log2 of memory depth in words (256 words).
REQ-004 SHALL provide parameter WAIT_CYCLES, default 2, range 0..15, wait states inserted before every response.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have: BUS_valid  input  1  initiator request valid.
REQ-007 SHALL have: BUS_mode  input  1  0 = read, 1 = write.
REQ-008 SHALL have: BUS_addr  input  ADDR_WIDTH  byte address, word-aligned.
REQ-009 SHALL have: BUS_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have: BUS_rready  input  1  initiator ready to take read data.
REQ-011 SHALL have: BUS_wready  output  1  write completed, one-cycle pulse.
REQ-012 SHALL have: BUS_rvalid  output  1  read data valid.
REQ-013 SHALL have: BUS_rdata  output  DATA_WIDTH  read data.
REQ-014 SHALL have: busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have: range_err  output  1  one-cycle pulse on out-of-range access.

Function
REQ-016 SHALL implement states IDLE, WAIT, WRESP, RRESP, RELEASE; all outputs registered.
REQ-017 SHALL index memory with BUS_addr[DEPTH_LOG2+1:2]; BUS_addr[1:0] ignored; access is in range iff BUS_addr[ADDR_WIDTH-1:DEPTH_LOG2+2] == 0.
REQ-018 IDLE: on an edge with BUS_valid=1, SHALL latch BUS_mode, BUS_addr, BUS_wdata; go to WAIT with counter = WAIT_CYCLES-1, or directly to WRESP/RRESP (by mode) if WAIT_CYCLES=0.
REQ-019 WAIT: counter SHALL decrement each edge; on the edge where counter = 0, go to WRESP (write) or RRESP (read).
REQ-020 Latency: request first sampled at edge k SHALL yield BUS_wready/BUS_rvalid first high in the cycle after edge k+WAIT_CYCLES.
REQ-021 Write: memory SHALL be updated on the edge entering WRESP; BUS_wready high exactly one cycle; then RELEASE.
REQ-022 Read: BUS_rdata SHALL hold mem[index] (0 if out of range) and BUS_rvalid stay high, both stable, until an edge samples BUS_rready=1; then RELEASE with BUS_rvalid=0.
REQ-023 Out-of-range write SHALL not modify memory but still complete with BUS_wready; range_err SHALL pulse in the same cycle as the first BUS_wready/BUS_rvalid of any out-of-range access.
REQ-024 RELEASE: SHALL stay until BUS_valid=0 is sampled, then IDLE; a held BUS_valid SHALL never start a second transaction.
REQ-025 Abort: BUS_valid=0 sampled in WAIT or RRESP SHALL return to IDLE, with no memory write, no BUS_wready, BUS_rvalid cleared.
REQ-026 BUS_rdata SHALL be 0 whenever BUS_rvalid=0.
REQ-027 BUS_mode/BUS_addr/BUS_wdata changes after acceptance SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counter 0, BUS_wready=0, BUS_rvalid=0, BUS_rdata=0, busy=0, range_err=0.
REQ-029 Memory contents SHALL not be reset; a write pending in WAIT at reset SHALL be discarded.
REQ-030 After rst_n rises, the first edge with BUS_valid=1 SHALL be accepted normally.

Verification (WAIT_CYCLES=2, DEPTH_LOG2=8)
REQ-031 Write 0xDEADBEEF to 0x10 at edge k -> BUS_wready high exactly in cycle after edge k+2; then read 0x10 -> BUS_rvalid, BUS_rdata=0xDEADBEEF.
REQ-032 Read with BUS_rready held 0 for 5 cycles then 1 -> BUS_rvalid/BUS_rdata stable throughout, drop after rready edge.
REQ-033 BUS_valid held high 10 cycles after write to 0x04 -> exactly one BUS_wready pulse, busy high until valid drops.
REQ-034 Write 0x12345678 to 0x400 -> range_err pulse, BUS_wready pulse; read 0x000 unchanged; read 0x400 -> BUS_rdata=0.
REQ-035 Write 0xA5A5A5A5 to 0x08 aborted (BUS_valid=0 one cycle after accept) -> no BUS_wready, mem[2] keeps prior value.
REQ-036 rst_n=0 asserted in WAIT of write to 0x0C -> outputs 0 immediately, mem[3] unchanged after reset release.
